// File: rtl/stack_pkg.sv
// Shared definitions for the stack unit: default widths, the stack pointer
// start value, the {push,pop} command encodings and the count-width helper.
package stack_pkg;

    localparam int         DATA_W_DEF = 8;
    localparam logic [7:0] SP_TOP_DEF = 8'hFF;

    // Command encodings, formed as {push, pop}
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_POP  = 2'b01;
    localparam logic [1:0] CMD_PUSH = 2'b10;
    localparam logic [1:0] CMD_REPL = 2'b11;

    // The count must represent 0..DEPTH inclusive, hence one extra bit
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack entry storage: DEPTH x DATA_W registers with one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module stack_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write one entry on the clock edge when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO stack for the register datapath. Tracks the entry count,
// derives the stack pointer (SP_TOP - count), registers the popped value
// and keeps sticky overflow/underflow flags.
// Optional feature macro: STACK_PEEK_EN adds the combinational top_data port.
module stack_unit
    import stack_pkg::*;
#(
    parameter int         DATA_W = DATA_W_DEF,
    parameter int         DEPTH  = 16,
    parameter logic [7:0] SP_TOP = SP_TOP_DEF,
    localparam int        CNT_W  = cnt_w(DEPTH),
    localparam int        AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
`ifdef STACK_PEEK_EN
    output logic [DATA_W-1:0] top_data,
`endif
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [7:0]        sp_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [AW-1:0]    ONE_ADDR = AW'(1);

    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_pop_valid;
    logic              r_ovf_err;
    logic              r_unf_err;

    logic [1:0]        w_cmd;
    logic              w_full;
    logic              w_empty;
    logic [AW-1:0]     w_top_addr;
    logic [DATA_W-1:0] w_top_rdata;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_pop_acc;
    logic [DATA_W-1:0] w_pop_nxt;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    assign w_cmd      = {push, pop};
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    // Low bits of count minus one; at count==DEPTH the low bits are zero and
    // this wraps to DEPTH-1, which is exactly the top entry.
    assign w_top_addr = r_count[AW-1:0] - ONE_ADDR;

    // Decode the command into storage write, next count and pop result
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_count[AW-1:0];
        w_count_nxt = r_count;
        w_pop_acc   = 1'b0;
        w_pop_nxt   = r_pop_data;
        w_ovf_evt   = 1'b0;
        w_unf_evt   = 1'b0;
        case (w_cmd)
            CMD_PUSH: begin
                if (w_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + ONE_CNT;
                end
            end
            CMD_POP: begin
                if (w_empty) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_pop_acc   = 1'b1;
                    w_pop_nxt   = w_top_rdata;
                    w_count_nxt = r_count - ONE_CNT;
                end
            end
            CMD_REPL: begin
                w_pop_acc = 1'b1;
                if (w_empty) begin
                    // Nothing stored: the pushed value passes straight through
                    w_pop_nxt = push_data;
                end else begin
                    w_we      = 1'b1;
                    w_waddr   = w_top_addr;
                    w_pop_nxt = w_top_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage; writes are suppressed while reset is held so an aborted
    // operation leaves the entries untouched.
    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we & ~rst),
        .i_waddr (w_waddr),
        .i_wdata (push_data),
        .i_raddr (w_top_addr),
        .o_rdata (w_top_rdata)
    );

    // Count, pop result and sticky error flags; an error set beats err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_unf_err   <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_pop_valid <= w_pop_acc;
            if (w_pop_acc) begin
                r_pop_data <= w_pop_nxt;
            end
            if (w_ovf_evt) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
            if (w_unf_evt) begin
                r_unf_err <= 1'b1;
            end else if (err_clr) begin
                r_unf_err <= 1'b0;
            end
        end
    end

    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign sp_out    = SP_TOP - 8'(r_count);
    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign ovf_err   = r_ovf_err;
    assign unf_err   = r_unf_err;

`ifdef STACK_PEEK_EN
    assign top_data = w_empty ? '0 : w_top_rdata;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Testbench for stack_unit: directed scenarios plus randomized push/pop
// traffic, compared against a queue-based LIFO model.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       err_clr = 1'b0;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [7:0] sp_out;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       unf_err;
`ifdef STACK_PEEK_EN
    logic [7:0] top_data;
`endif

    stack_unit dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .err_clr   (err_clr),
`ifdef STACK_PEEK_EN
        .top_data  (top_data),
`endif
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .sp_out    (sp_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_q [$];
    logic [7:0] m_pd;
    logic       m_pv;
    logic       m_ovf;
    logic       m_unf;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pd  = 8'h00;
        m_pv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic o, input logic [7:0] d, input logic c);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_pv = 1'b0;
        if (p && !o) begin
            if (m_q.size() == 16) m_ovf = 1'b1;
            else m_q.push_back(d);
        end else if (!p && o) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else begin
                m_pd = m_q.pop_back();
                m_pv = 1'b1;
            end
        end else if (p && o) begin
            m_pv = 1'b1;
            if (m_q.size() == 0) m_pd = d;
            else begin
                m_pd = m_q[$];
                m_q[$] = d;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".count"},   32'(count),     32'(sz));
        chk({tag, ".sp"},      32'(sp_out),    32'(8'hFF - 8'(sz)));
        chk({tag, ".full"},    32'(full),      32'(sz == 16));
        chk({tag, ".empty"},   32'(empty),     32'(sz == 0));
        chk({tag, ".pvalid"},  32'(pop_valid), 32'(m_pv));
        chk({tag, ".pdata"},   32'(pop_data),  32'(m_pd));
        chk({tag, ".ovf"},     32'(ovf_err),   32'(m_ovf));
        chk({tag, ".unf"},     32'(unf_err),   32'(m_unf));
`ifdef STACK_PEEK_EN
        chk({tag, ".top"},     32'(top_data),  32'((sz == 0) ? 8'h00 : m_q[$]));
`endif
    endtask

    // Apply one command for one clock edge, then compare against the model
    task automatic step(input string tag, input logic p, input logic o,
                        input logic [7:0] d, input logic c);
        push = p; pop = o; push_data = d; err_clr = c;
        @(posedge clk);
        model_edge(p, o, d, c);
        #1;
        check_all(tag);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset");
        chk("reset.sp_const", 32'(sp_out), 32'h0000_00FF);

        // LIFO order
        step("push11", 1, 0, 8'h11, 0);
        step("push22", 1, 0, 8'h22, 0);
        step("push33", 1, 0, 8'h33, 0);
        chk("sp_after3", 32'(sp_out), 32'h0000_00FC);
        step("pop1", 0, 1, 8'h00, 0);
        chk("pop1_const", 32'(pop_data), 32'h33);
        step("pop2", 0, 1, 8'h00, 0);
        chk("pop2_const", 32'(pop_data), 32'h22);
        step("pop3", 0, 1, 8'h00, 0);
        chk("pop3_const", 32'(pop_data), 32'h11);
        chk("empty_end", 32'(empty), 32'h1);

        // Fill, overflow, pop, clear
        for (int i = 0; i < 16; i++) step("fill", 1, 0, 8'(i), 0);
        chk("full_sp", 32'(sp_out), 32'h0000_00EF);
        step("ovf_push", 1, 0, 8'hAA, 0);
        chk("ovf_const", 32'(ovf_err), 32'h1);
        chk("ovf_count", 32'(count), 32'd16);
        step("pop_full", 0, 1, 8'h00, 0);
        chk("pop_full_const", 32'(pop_data), 32'h0F);
        step("clr_ovf", 0, 0, 8'h00, 1);
        chk("clr_ovf_const", 32'(ovf_err), 32'h0);
        while (m_q.size() > 0) step("drain", 0, 1, 8'h00, 0);

        // Underflow and empty bypass
        step("unf_pop", 0, 1, 8'h00, 0);
        chk("unf_const", 32'(unf_err), 32'h1);
        step("bypass", 1, 1, 8'h5C, 0);
        chk("bypass_const", 32'(pop_data), 32'h5C);
        chk("bypass_unf", 32'(unf_err), 32'h1);
        step("clr_unf", 0, 0, 8'h00, 1);

        // Replace top
        step("r_push11", 1, 0, 8'h11, 0);
        step("r_push22", 1, 0, 8'h22, 0);
        step("repl", 1, 1, 8'h99, 0);
        chk("repl_const", 32'(pop_data), 32'h22);
        chk("repl_count", 32'(count), 32'd2);
        step("repl_pop", 0, 1, 8'h00, 0);
        chk("repl_pop_const", 32'(pop_data), 32'h99);

        // Error set beats clear on the same edge
        while (m_q.size() > 0) step("drain2", 0, 1, 8'h00, 0);
        step("set_vs_clr", 0, 1, 8'h00, 1);
        step("clr2", 0, 0, 8'h00, 1);

        // Randomized traffic with a drifting push bias to reach full and empty
        for (int i = 0; i < 800; i++) begin
            int bias;
            int r;
            logic p;
            logic o;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            r = int'($urandom_range(0, 99));
            p = (r < bias);
            o = (int'($urandom_range(0, 99)) < (100 - bias));
            step("rand", p, o, 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        // Reset in the middle of an active push
        while (m_q.size() > 0) step("drain3", 0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 8'(8'h40 + i), 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        push = 1'b1; push_data = 8'h77;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_sp", 32'(sp_out), 32'h0000_00FF);
        chk("rst_pvalid", 32'(pop_valid), 32'h0);
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        push = 1'b0;
        rst = 1'b0;
        step("post_rst_pop", 0, 1, 8'h00, 0);
        chk("post_rst_unf", 32'(unf_err), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
